// File: rtl/lfsr_prompt_bank.sv
// Bank of per-channel Fibonacci LFSRs that supplies round prompts through a req/valid handshake.
// Supports runtime reseeding, optional rejection of a repeated prompt, and a wrapping round counter.
module lfsr_prompt_bank #(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SEED_BASE   = 1,
  parameter int unsigned NO_REPEAT   = 1,
  parameter int unsigned MAX_RETRIES = 7
) (
  input  logic                      i_clock_50,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_seed_load,
  input  logic [WIDTH-1:0]          i_seed_in,
  input  logic                      i_req,
  output logic                      o_ready,
  output logic                      o_valid,
  output logic [CHANNELS*WIDTH-1:0] o_prompt,
  output logic [7:0]                o_round_count
);

  localparam int unsigned PW = CHANNELS * WIDTH;
  localparam int unsigned RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [7:0]  TAP_MASK = (WIDTH == 3) ? 8'h06 :
                                     (WIDTH == 4) ? 8'h0C :
                                     (WIDTH == 5) ? 8'h14 :
                                     (WIDTH == 6) ? 8'h30 :
                                     (WIDTH == 7) ? 8'h60 : 8'hB8;
  localparam logic [WIDTH-1:0] TAPS = TAP_MASK[WIDTH-1:0];

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RETRY, S_DELIVER} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_lfsr, w_lfsr_nxt, w_lfsr_rst;
  logic [PW-1:0]   r_snap, w_snap_nxt;
  logic [PW-1:0]   r_prompt, w_prompt_nxt;
  logic [RW-1:0]   r_retry, w_retry_nxt;
  logic [7:0]      r_count, w_count_nxt;
  logic            r_ready, w_ready_nxt;
  logic            r_valid, w_valid_nxt;
  logic            w_repeat;

  function automatic logic [WIDTH-1:0] nonzero(input logic [WIDTH-1:0] v);
    return (v == '0) ? WIDTH'(1) : v;
  endfunction

  // Per-channel step / reseed; a zero seed is forced to 1 so the LFSR never locks up.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_seed;
    assign w_cur  = r_lfsr[c*WIDTH +: WIDTH];
    assign w_step = {w_cur[WIDTH-2:0], ^(w_cur & TAPS)};
    assign w_seed = nonzero(i_seed_in ^ WIDTH'(c));
    assign w_lfsr_rst[c*WIDTH +: WIDTH] = nonzero(WIDTH'(SEED_BASE + c));
    assign w_lfsr_nxt[c*WIDTH +: WIDTH] = i_seed_load ? w_seed :
                                          (i_enable ? w_step : w_cur);
  end

  always_ff @(posedge i_clock_50 or posedge i_reset) begin
    if (i_reset) r_lfsr <= w_lfsr_rst;
    else         r_lfsr <= w_lfsr_nxt;
  end

  assign w_repeat = (NO_REPEAT != 0) && (r_snap == r_prompt);

  always_ff @(posedge i_clock_50 or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_req) w_state_nxt = S_CHECK;
      S_CHECK:   w_state_nxt = (w_repeat && (r_retry < RW'(MAX_RETRIES))) ? S_RETRY : S_DELIVER;
      S_RETRY:   w_state_nxt = S_CHECK;
      S_DELIVER: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for the datapath and the registered handshake outputs.
  always_comb begin
    w_snap_nxt   = r_snap;
    w_retry_nxt  = r_retry;
    w_prompt_nxt = r_prompt;
    w_count_nxt  = r_count;
    w_valid_nxt  = 1'b0;
    w_ready_nxt  = (w_state_nxt == S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_snap_nxt  = r_lfsr;
          w_retry_nxt = '0;
        end
      end
      S_RETRY: begin
        w_snap_nxt  = r_lfsr;
        w_retry_nxt = r_retry + RW'(1);
      end
      S_DELIVER: begin
        w_prompt_nxt = r_snap;
        w_valid_nxt  = 1'b1;
        w_count_nxt  = r_count + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock_50 or posedge i_reset) begin
    if (i_reset) begin
      r_snap   <= '0;
      r_retry  <= '0;
      r_prompt <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
    end else begin
      r_snap   <= w_snap_nxt;
      r_retry  <= w_retry_nxt;
      r_prompt <= w_prompt_nxt;
      r_count  <= w_count_nxt;
      r_ready  <= w_ready_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  assign o_ready       = r_ready;
  assign o_valid       = r_valid;
  assign o_prompt      = r_prompt;
  assign o_round_count = r_count;

endmodule

// File: tb/tb_lfsr_prompt_bank.sv
// Self-checking bench for lfsr_prompt_bank (default parameters) with a transaction-level model.
module tb_lfsr_prompt_bank;

  localparam int unsigned W    = 3;
  localparam int unsigned CH   = 4;
  localparam int unsigned MAXR = 7;
  localparam int unsigned PW   = CH * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sl;
  logic [W-1:0]  seed;
  logic          req;
  logic          ready;
  logic          valid;
  logic [PW-1:0] prompt;
  logic [7:0]    rc;

  always #5 clk = ~clk;

  lfsr_prompt_bank dut (
    .i_clock_50    (clk),
    .i_reset       (rst),
    .i_enable      (en),
    .i_seed_load   (sl),
    .i_seed_in     (seed),
    .i_req         (req),
    .o_ready       (ready),
    .o_valid       (valid),
    .o_prompt      (prompt),
    .o_round_count (rc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int m_lfsr[CH];
  int m_prompt;
  int m_count;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Maximal-length 3-bit sequence: multiply by two mod 8, feed in parity of bits 2 and 1.
  function automatic int step(input int s);
    int fb;
    fb = ((s / 4) % 2) ^ ((s / 2) % 2);
    return (s * 2 + fb) % 8;
  endfunction

  function automatic int fixz(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) m_lfsr[c] = fixz((1 + c) % 8);
    m_prompt = 0;
    m_count  = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (sl) begin
      for (int c = 0; c < CH; c++) m_lfsr[c] = fixz(int'(seed) ^ c);
    end else if (en) begin
      for (int c = 0; c < CH; c++) m_lfsr[c] = step(m_lfsr[c]);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // One request/deliver transaction; expected prompt and latency come from the model.
  task automatic do_round(input bit poke_busy, output int lat);
    int tmp[CH];
    int snap;
    int k;
    for (int c = 0; c < CH; c++) tmp[c] = m_lfsr[c];
    snap = 0;
    for (int c = 0; c < CH; c++) snap += tmp[c] << (c * W);
    k = 0;
    while (snap == m_prompt && k < int'(MAXR)) begin
      k++;
      if (en) for (int c = 0; c < CH; c++) tmp[c] = step(step(tmp[c]));
      snap = 0;
      for (int c = 0; c < CH; c++) snap += tmp[c] << (c * W);
    end
    req = 1'b1;
    tick();
    req = 1'b0;
    check_eq("ready_busy", 32'(ready), 32'd0);
    lat = 0;
    while (!valid && lat < 40) begin
      if (poke_busy && lat == 0) req = 1'b1;
      tick();
      req = 1'b0;
      lat++;
    end
    m_prompt = snap;
    m_count  = (m_count + 1) % 256;
    check_eq("latency", 32'(lat), 32'(2 + 2 * k));
    check_eq("prompt", 32'(prompt), 32'(m_prompt));
    check_eq("round_count", 32'(rc), 32'(m_count));
    check_eq("ready_after", 32'(ready), 32'd1);
    tick();
    check_eq("valid_pulse", 32'(valid), 32'd0);
    check_eq("prompt_hold", 32'(prompt), 32'(m_prompt));
    if (poke_busy) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        check_eq("no_extra_valid", 32'(valid), 32'd0);
      end
    end
  endtask

  initial begin
    int seq0[8];
    int seq1[8];
    int lat;
    logic [PW-1:0] prev;
    seq0 = '{1, 2, 5, 3, 7, 6, 4, 1};
    seq1 = '{2, 5, 3, 7, 6, 4, 1, 2};
    rst = 1'b1; en = 1'b0; sl = 1'b0; seed = '0; req = 1'b0;
    model_reset();
    #2;
    do_reset();
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_prompt", 32'(prompt), 32'd0);
    check_eq("rst_count", 32'(rc), 32'd0);

    // Known W=3 sequence for channels 0 and 1, observed through a frozen snapshot.
    for (int k = 0; k < 8; k++) begin
      do_reset();
      en = 1'b1;
      for (int i = 0; i < k; i++) tick();
      en = 1'b0;
      do_round(1'b0, lat);
      check_eq("seq_ch0", 32'(prompt[2:0]), 32'(seq0[k]));
      check_eq("seq_ch1", 32'(prompt[5:3]), 32'(seq1[k]));
    end

    // Handshake after reset with LFSRs frozen.
    do_reset();
    en = 1'b0;
    do_round(1'b0, lat);
    check_eq("hs_latency", 32'(lat), 32'd2);
    check_eq("hs_prompt", 32'(prompt), 32'h8D1);
    check_eq("hs_count", 32'(rc), 32'd1);

    // Repeat rejection: frozen LFSRs exhaust the retries and deliver the repeat.
    do_round(1'b0, lat);
    check_eq("nr_latency", 32'(lat), 32'd16);
    check_eq("nr_prompt", 32'(prompt), 32'h8D1);
    prev = prompt;
    en = 1'b1;
    do_round(1'b0, lat);
    check_eq("nr_differs", 32'(prompt != prev), 32'd1);

    // Reseed with zero, then a request while busy is ignored.
    en = 1'b0; sl = 1'b1; seed = '0;
    tick();
    sl = 1'b0;
    do_round(1'b1, lat);
    check_eq("reseed_prompt", 32'(prompt), 32'h689);

    // Asynchronous reset while in DELIVER.
    sl = 1'b1; seed = 3'd5;
    tick();
    sl = 1'b0;
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_ready", 32'(ready), 32'd1);
    check_eq("mid_rst_valid", 32'(valid), 32'd0);
    check_eq("mid_rst_prompt", 32'(prompt), 32'd0);
    check_eq("mid_rst_count", 32'(rc), 32'd0);
    tick();
    rst = 1'b0;
    model_reset();

    // Randomized rounds; 256 deliveries wrap the counter to zero.
    for (int r = 0; r < 256; r++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        sl = 1'b1;
        seed = W'($urandom);
        tick();
        sl = 1'b0;
      end
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      do_round(1'($urandom_range(0, 1)), lat);
    end
    check_eq("count_wrap", 32'(rc), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
